ifu_pc_gen: RTL
===============

// Module: ifu_pc_gen
// PURPOSE
//  Parametrised program-counter generator for the IFU; generalises the fixed 4-bit incrementer.
//  Holds the fetch PC and advances it by a configurable power-of-two STEP on each accepted fetch.
//  Supports branch/jump redirect with alignment, halt/resume, and a valid/ready handshake to fetch.
//  Reports increment wrap-around.
// PARAMETERS
//  WIDTH      32        PC width in bits (>=4)
//  STEP       4         increment per accepted fetch; power of two, 1..2**(WIDTH-1)
//  RESET_VEC  '0        PC value loaded on reset; must be STEP-aligned
// PORTS
//  clk             in   1      single clock, rising edge
//  rst             in   1      synchronous, active-high reset
//  en              in   1      start fetching; sampled in IDLE only
//  halt            in   1      level; stop issuing PCs while high
//  redirect_valid  in   1      load new PC this cycle
//  redirect_addr   in   WIDTH  redirect target; low log2(STEP) bits ignored (forced 0)
//  pc_ready        in   1      fetch stage accepts pc
//  pc              out  WIDTH  current fetch address, always STEP-aligned
//  pc_valid        out  1      pc is offered to fetch
//  wrap            out  1      1-cycle pulse: last increment overflowed 2**WIDTH
//  state           out  2      FSM state (debug), encoding from ifu_pkg
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc=RESET_VEC, pc_valid=0, wrap=0, state=IDLE; dominates all inputs.
//  FSM states: IDLE=0, RUN=1, HALT=2; pc_valid is registered and equals (state==RUN).
//   IDLE: en=1 & halt=0 -> RUN; otherwise stay.
//   RUN : halt=1 -> HALT (pc_valid low from next cycle); otherwise stay.
//   HALT: halt=0 -> RUN; en ignored.
//  Transfer = pc_valid & pc_ready.
//  PC update priority per cycle: rst > redirect_valid > transfer > hold.
//   redirect: pc <= {redirect_addr[WIDTH-1:LSB], LSB'0} with LSB=log2(STEP);
//    accepted in any state; a simultaneous transfer is consumed without increment.
//   transfer: pc <= pc + STEP modulo 2**WIDTH; wrap=1 next cycle iff carry-out, else 0.
//   hold: pc_valid=1 & pc_ready=0 -> pc stable until transfer or redirect (redirect = flush).
//  wrap is 0 in every cycle not immediately following a wrapping increment.
//  Halt and transfer in the same cycle: the increment happens; the FSM then enters HALT.
//  Redirect in IDLE/HALT updates pc; the new pc is issued on entry to RUN.
//  No combinational path from inputs to outputs; all outputs are registered.
// STRUCTURE
//  ifu_pkg: typedef enum logic[1:0] pc_state_e {PC_IDLE, PC_RUN, PC_HALT}; PC_WIDTH default.
//  Sub-module pc_incr #(WIDTH,STEP): combinational in + STEP -> {carry,out};
//   adds only at bit log2(STEP) upward; bits below pass through as 0.
//  Top: FSM register, PC register with priority mux, wrap register.
// TESTING (WIDTH=8, STEP=4, RESET_VEC=8'hF0)
//  1 rst 2 cycles, en=1, pc_ready=1 -> cycle after en: pc_valid=1, pc=F0, state=RUN.
//  2 pc_ready held 1 -> pc F0,F4,F8,FC,00,04; wrap=1 only in the cycle pc=00.
//  3 pc=F4 valid, pc_ready=0 for 3 cycles -> pc stays F4; ready=1 -> F8 next.
//  4 redirect_valid=1, redirect_addr=37, pc_ready=1 -> next pc=34 (no +4); following pc=38.
//  5 halt=1 in RUN at pc=08 with ready=1 -> next pc_valid=0, pc=0C held; halt=0 -> valid=1, pc=0C.
//  6 rst=1 mid-run at pc=20 with redirect_valid=1 -> next pc=F0, pc_valid=0, wrap=0, state=IDLE.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types for the IFU program-counter generator.
// State encoding is visible on the debug port, so the values are fixed.
package ifu_pkg;

    typedef enum logic [1:0] {
        PC_IDLE = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

    localparam int PC_WIDTH = 32;

endpackage

// File: rtl/ifu_pc_gen_incr.sv
// Combinational PC incrementer: adds STEP at bit log2(STEP) and reports carry-out.
// Bits below log2(STEP) are forced to zero so the result is always STEP-aligned.
module pc_incr #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0] i_pc,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_carry
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN  = ~(STEP_V - WIDTH'(1));

    logic [WIDTH:0] w_sum;

    assign w_sum   = {1'b0, i_pc & ALIGN} + {1'b0, STEP_V};
    assign o_pc    = w_sum[WIDTH-1:0];
    assign o_carry = w_sum[WIDTH];

endmodule

// File: rtl/ifu_pc_gen.sv
// IFU fetch PC generator: IDLE/RUN/HALT control, redirect, valid/ready issue and
// wrap-around reporting. Every output comes straight from a register.
module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             halt,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_addr,
    input  logic             pc_ready,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             wrap,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] ALIGN = ~(WIDTH'(STEP) - WIDTH'(1));

    pc_state_e        r_state;
    pc_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic             r_pc_valid;
    logic             r_wrap;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_carry;
    logic             w_xfer;

    pc_incr #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_incr (
        .i_pc    (r_pc),
        .o_pc    (w_pc_inc),
        .o_carry (w_carry)
    );

    assign w_xfer = r_pc_valid & pc_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PC_IDLE: if (en && !halt) w_state_nxt = PC_RUN;
            PC_RUN:  if (halt)        w_state_nxt = PC_HALT;
            PC_HALT: if (!halt)       w_state_nxt = PC_RUN;
            default:                  w_state_nxt = PC_IDLE;
        endcase
    end

    // Redirect wins over a concurrent transfer: the accepted PC is flushed, not incremented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= PC_IDLE;
            r_pc       <= RESET_VEC;
            r_pc_valid <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc_valid <= (w_state_nxt == PC_RUN);
            r_wrap     <= w_xfer & ~redirect_valid & w_carry;
            if (redirect_valid)
                r_pc <= redirect_addr & ALIGN;
            else if (w_xfer)
                r_pc <= w_pc_inc;
        end
    end

    assign pc       = r_pc;
    assign pc_valid = r_pc_valid;
    assign wrap     = r_wrap;
    assign state    = r_state;

endmodule
